// File: rtl/shift_pkg.sv
// Shared definitions for the register-specified shift operand sequencer:
// shift type encodings, FSM states, word width, count limits and the
// effective-count helper.
package shift_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 6;

    // Amount thresholds applied to Rs[7:0]
    localparam logic [7:0] AMT_LIM_32 = 8'd32;
    localparam logic [7:0] AMT_LIM_33 = 8'd33;

    typedef enum logic [1:0] {
        SHIFT_LSL = 2'b00,
        SHIFT_LSR = 2'b01,
        SHIFT_ASR = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Number of single-bit steps needed. Anything beyond 33 (LSL/LSR) or
    // 32 (ASR) gives the same result, and ROR only cares about amount[4:0].
    function automatic logic [CNT_W-1:0] eff_count(input shift_t t,
                                                   input logic [7:0] amt);
        logic [CNT_W-1:0] cnt;
        case (t)
            SHIFT_LSL, SHIFT_LSR:
                cnt = (amt >= AMT_LIM_33) ? CNT_W'(AMT_LIM_33) : amt[CNT_W-1:0];
            SHIFT_ASR:
                cnt = (amt >= AMT_LIM_32) ? CNT_W'(AMT_LIM_32) : amt[CNT_W-1:0];
            default:
                cnt = {1'b0, amt[4:0]};
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/shift_step_unit.sv
// Combinational shifter for one RUN cycle: shifts the value by 0..STEP bits
// and reports the last bit shifted out. Holds all fill and carry rules.
module shift_step_unit
    import shift_pkg::*;
#(
    parameter int unsigned STEP = 4
) (
    input  shift_t             i_type,
    input  logic [WORD_W-1:0]  i_value,
    input  logic               i_carry,
    input  logic [CNT_W-1:0]   i_amt,
    output logic [WORD_W-1:0]  o_value,
    output logic               o_carry
);

    logic [WORD_W-1:0] w_v;
    logic              w_c;

    // Chain of single-bit shifts; stages beyond i_amt pass through untouched
    always_comb begin
        w_v = i_value;
        w_c = i_carry;
        for (int unsigned k = 0; k < STEP; k++) begin
            if (CNT_W'(k) < i_amt) begin
                case (i_type)
                    SHIFT_LSL: begin
                        w_c = w_v[WORD_W-1];
                        w_v = {w_v[WORD_W-2:0], 1'b0};
                    end
                    SHIFT_LSR: begin
                        w_c = w_v[0];
                        w_v = {1'b0, w_v[WORD_W-1:1]};
                    end
                    SHIFT_ASR: begin
                        w_c = w_v[0];
                        w_v = {w_v[WORD_W-1], w_v[WORD_W-1:1]};
                    end
                    default: begin
                        // ROR: bit rotated into 31 is also the carry
                        w_c = w_v[0];
                        w_v = {w_v[0], w_v[WORD_W-1:1]};
                    end
                endcase
            end
        end
        o_value = w_v;
        o_carry = w_c;
    end

endmodule

// File: rtl/shift_operand_sequencer.sv
// Multi-cycle register-specified shifter operand sequencer. Shifts rm by up
// to STEP bits per RUN cycle and applies the ARM out-of-range rules.
// Optional macro SHIFT_SEQ_SATURATE_BYPASS_EN: LSL/LSR/ASR with amount>=32
// resolve at acceptance instead of iterating.
module shift_operand_sequencer
    import shift_pkg::*;
#(
    parameter int unsigned STEP = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              ready,
    input  logic [1:0]        shift_type,
    input  logic [7:0]        amount,
    input  logic [WORD_W-1:0] rm,
    input  logic              carry_in,
    output logic [WORD_W-1:0] out,
    output logic              carry_out,
    output logic              done
);

    localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);

    state_t            r_state;
    state_t            w_next;
    shift_t            r_type;
    logic [WORD_W-1:0] r_out;
    logic              r_carry;
    logic [CNT_W-1:0]  r_rem;

    shift_t            w_type_in;
    logic [CNT_W-1:0]  w_count;
    logic              w_accept;
    logic              w_bypass;
    logic [WORD_W-1:0] w_byp_out;
    logic              w_byp_carry;
    logic [CNT_W-1:0]  w_step_amt;
    logic [CNT_W-1:0]  w_rem_next;
    logic [WORD_W-1:0] w_step_val;
    logic              w_step_carry;

    assign w_type_in  = shift_t'(shift_type);
    assign w_count    = eff_count(w_type_in, amount);
    assign ready      = (r_state != ST_RUN);
    assign done       = (r_state == ST_DONE);
    assign w_accept   = start && ready;
    assign w_step_amt = (r_rem < STEP_C) ? r_rem : STEP_C;
    assign w_rem_next = r_rem - w_step_amt;
    assign out        = r_out;
    assign carry_out  = r_carry;

`ifdef SHIFT_SEQ_SATURATE_BYPASS_EN
    assign w_bypass = (w_type_in != SHIFT_ROR) && (amount >= AMT_LIM_32);
`else
    assign w_bypass = 1'b0;
`endif

    // Closed-form result for saturated LSL/LSR/ASR amounts
    always_comb begin
        w_byp_out   = '0;
        w_byp_carry = 1'b0;
        case (w_type_in)
            SHIFT_LSL: w_byp_carry = (amount == AMT_LIM_32) ? rm[0] : 1'b0;
            SHIFT_LSR: w_byp_carry = (amount == AMT_LIM_32) ? rm[WORD_W-1] : 1'b0;
            default: begin
                w_byp_out   = {WORD_W{rm[WORD_W-1]}};
                w_byp_carry = rm[WORD_W-1];
            end
        endcase
    end

    shift_step_unit #(
        .STEP (STEP)
    ) u_step (
        .i_type  (r_type),
        .i_value (r_out),
        .i_carry (r_carry),
        .i_amt   (w_step_amt),
        .o_value (w_step_val),
        .o_carry (w_step_carry)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic; start is only honoured from IDLE or DONE
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start)
                    w_next = (w_count == '0 || w_bypass) ? ST_DONE : ST_RUN;
                else
                    w_next = ST_IDLE;
            end
            ST_RUN: begin
                if (w_rem_next == '0) w_next = ST_DONE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand/result datapath: load on acceptance, one step per RUN cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_type  <= SHIFT_LSL;
            r_out   <= '0;
            r_carry <= 1'b0;
            r_rem   <= '0;
        end else if (w_accept) begin
            r_type <= w_type_in;
            r_rem  <= '0;
            if (w_count == '0) begin
                // amount==0 keeps C; ROR by a non-zero multiple of 32 takes rm[31]
                r_out   <= rm;
                r_carry <= (amount == 8'd0) ? carry_in : rm[WORD_W-1];
            end else if (w_bypass) begin
                r_out   <= w_byp_out;
                r_carry <= w_byp_carry;
            end else begin
                r_out   <= rm;
                r_carry <= carry_in;
                r_rem   <= w_count;
            end
        end else if (r_state == ST_RUN) begin
            r_out   <= w_step_val;
            r_carry <= w_step_carry;
            r_rem   <= w_rem_next;
        end
    end

endmodule

// File: doc/shift_operand_sequencer.md
Name: shift_operand_sequencer

Overview:
- Multi-cycle controller that computes register-specified shifter operands: data-processing instructions with instruction[4]=1, where the shift amount comes from Rs[7:0].
- Sequences an iterative shift of Rm by up to STEP bits per cycle under an FSM and applies the ARM out-of-range rules for amounts 0, 32 and above 32.
- Sits beside the immediate-shift sign extender in the data path.
- The control unit starts it and stalls until done.

Parameters:
- STEP, 4, bits shifted per RUN cycle; power of two, 1..32.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when ready=1
- ready  output  1  FSM in IDLE or DONE, able to accept start
- shift_type  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
- amount  input  8  Rs[7:0]
- rm  input  32  operand to shift
- carry_in  input  1  current CPSR C flag
- out  output  32  shifted operand
- carry_out  output  1  shifter carry
- done  output  1  one-cycle pulse; out and carry_out are valid from this cycle

Behaviour:
- Reset (asynchronous, any state): state=IDLE, out=0, carry_out=0, done=0, ready=1.
- States: IDLE, RUN, DONE.
  - IDLE/DONE + start: latch shift_type, rm and carry_in, compute count, go to RUN; if count=0, go straight to DONE.
  - RUN: each cycle shift by s=min(remaining,STEP), remaining-=s. When remaining reaches 0, go to DONE.
  - DONE: done=1 for exactly that cycle; then IDLE unless start is accepted in the same cycle.
- start in RUN is ignored: no queueing, no error.
- Inputs are sampled only on acceptance; later changes have no effect on the operation in flight.
- Effective count:
  - LSL and LSR: min(amount,33).
  - ASR: min(amount,32).
  - ROR: amount[4:0].
- Step rules (carry = last bit shifted out):
  - LSL: shift left, zero fill.
  - LSR: shift right, zero fill.
  - ASR: shift right, sign fill.
  - ROR: rotate right; carry = resulting bit 31.
- Special cases:
  - amount=0 (any type): out=rm, carry_out=carry_in.
  - ROR with amount!=0 and amount[4:0]=0: out=rm, carry_out=rm[31].
- Rules above give by construction:
  - LSL 32: 0, C=rm[0]. LSL >32: 0, C=0.
  - LSR 32: 0, C=rm[31]. LSR >32: 0, C=0.
  - ASR >=32: all sign, C=rm[31].
- Latency: done asserts K+1 cycles after the acceptance edge, K=ceil(count/STEP).
- out and carry_out hold their value until the next accepted start. During RUN they show intermediate values, not valid.

Optional Feature:
- SHIFT_SEQ_SATURATE_BYPASS_EN defined: LSL, LSR and ASR with amount>=32 resolve at acceptance with K=0, so done comes 1 cycle later. Results are identical to the iterative path.
- Undefined: these cases iterate normally, up to ceil(33/STEP) RUN cycles.

Decomposition:
- Package shift_pkg:
  - shift type encodings SHIFT_LSL, SHIFT_LSR, SHIFT_ASR, SHIFT_ROR;
  - FSM state encoding;
  - WORD_W=32 and the count limits 32 and 33.
- Sub-module shift_step_unit: combinational one-step shifter. Inputs: type, value, step amount (0..STEP). Outputs: value and carry. Instantiated once; holds all fill and carry logic.

Test Plan:
1. LSL, rm=0x8000_0001, amount=1, carry_in=0 -> out=0x0000_0002, carry_out=1, done 2 cycles after accept (STEP=4).
2. LSR, rm=0x8000_0000, amount=32 -> out=0, carry_out=1, done 9 cycles after accept. With the macro defined -> done after 1 cycle, same result.
3. ASR, rm=0x8000_0000, amount=40 -> out=0xFFFF_FFFF, carry_out=1. LSL, rm=0xFFFF_FFFF, amount=33 -> out=0, carry_out=0.
4. ROR, rm=0x8000_0001, amount=0x20 -> out=0x8000_0001, carry_out=1, done after 1 cycle. amount=0, carry_in=1 -> out=rm, carry_out=1.
5. ROR, rm=0x0000_00F1, amount=4 -> out=0x1000_000F, carry_out=0. A start pulsed mid-RUN with different operands is ignored, and the result is unchanged.
6. reset_n low during RUN -> immediately ready=1, done=0, out=0. A new start after release completes normally with no residue.
